modred: RTL and testbench
=========================

# modred

Pipelined Barrett reducer that converts a 24-bit integer product back to a canonical 12-bit residue modulo Q = 3329. It sits directly downstream of the 12×12 integer multiplier in each butterfly/PE datapath and returns products to coefficient width. It carries a sideband tag so that NTT addresses and control travel with the data. A valid/ready handshake lets the PE stall it without losing data.

## Interface
- `Q`, 3329: modulus, 12 bits, odd.
- `TAG_W`, 8: sideband tag width, ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block can accept a beat this cycle.
- `in_data` in 24: product x, unsigned.
- `in_tag` in TAG_W: sideband, returned unmodified.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out 12: x mod Q, in [0, Q).
- `out_tag` out TAG_W: tag of the same beat.
- `ovf` out 1: present only with `MODRED_OVF_FLAG_EN` (see Configuration).

## Operation
- Constant M = floor(2^24 / Q) = 5039 for Q = 3329. M is 13 bits.
- Stage 1: p = x·M (37 bits). t = p[36:24] (13 bits). Register x, t, tag.
- Stage 2: r = x − t·Q. t·Q is 25 bits. The guaranteed range is r ∈ [0, 2Q), so only r[12:0] is kept. Register r, tag.
- Stage 3: out = (r ≥ Q) ? r − Q : r, taken to 12 bits. Register out_data, tag.
- The result is correct for every 24-bit x, including x ≥ Q², because the bound r < 2Q holds for all x < 2^24.
- Handshake:
  - adv = !v3 | out_ready, where v1..v3 are the stage valid bits.
  - When adv = 1, all stages shift: v1 ← in_valid, v2 ← v1, v3 ← v2. Data moves with the valid bits.
  - When adv = 0, all stage registers hold.
  - in_ready = adv, which is combinational from out_ready and v3.
  - A beat is accepted on in_valid & in_ready and retired on out_valid & out_ready.
- Bubbles propagate as v = 0 and never appear at the output as valid.
- Data and tag registers may load only when their valid is set. Their value is don't-care while valid = 0.
- out_valid = v3. out_data and out_tag must stay stable while out_valid & !out_ready.

## Timing
- Latency: 3 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 beat per cycle while out_ready is held high.
- Stall: if out_ready falls with out_valid high, in_ready falls in the same cycle. Nothing is accepted or dropped. Flow resumes on the cycle out_ready returns.
- Simultaneous accept and retire in one cycle is legal and keeps full throughput.
- Reset values (asynchronous, while `reset` = 0):
  - v1..v3 = 0, out_valid = 0, out_data = 0, out_tag = 0, ovf = 0.
  - in_ready = 1 immediately, since v3 = 0.
- Reset asserted mid-stream discards all in-flight beats. The first cycle after release behaves as an empty pipe.

## Configuration
- Macro: `MODRED_OVF_FLAG_EN`.
- Defined:
  - Port `ovf` exists.
  - `ovf` is a sticky flag, set on the cycle after any accepted beat with x ≥ Q² (11082241).
  - It is cleared only by reset.
  - It is diagnostic only. Results for such x remain correct mod Q.
- Undefined: the port and its comparator are absent. Datapath behaviour is identical.

## Structure
- The shared package holds:
  - `KYBER_Q` = 3329.
  - `BARRETT_M` = 5039.
  - `BARRETT_K` = 24.
  - `KYBER_Q2` = 11082241.
  - The coefficient typedef (12 bits) and the product typedef (24 bits).
- One sub-module: `modred_csub`, the combinational conditional subtract r ∈ [0, 2Q) → [0, Q). It is reused in the adders of the butterfly.
- Both multipliers in stages 1 and 2 are inferred `*` marked for DSP mapping, matching the upstream multiplier style.

## Test plan
- Corner values, out_ready held at 1: x = 0 → 0; x = 3329 → 0; x = 3328 → 3328; x = 3328·3328 = 11075584 → 1; x = 16777215 → 2384. Each result appears exactly 3 cycles after acceptance.
- Stream 10000 random x < Q² with incrementing tags → every output equals x mod Q, with tags in order and none lost or duplicated.
- Backpressure:
  - Send 6 back-to-back beats.
  - Drop out_ready for 4 cycles while beat 1 is at the output.
  - Required: out_data and out_tag are stable and in_ready = 0 throughout. All 6 beats drain in order after release.
- Bubbles: send in_valid = 1,0,1,0,1 with tags 1,2,3 → out_valid follows the same pattern 3 cycles later, with tags 1,2,3.
- Reset mid-stream:
  - Assert `reset` low with 3 beats in flight.
  - Required: out_valid = 0 at once, no stale beat after release, and in_ready = 1.
- With `MODRED_OVF_FLAG_EN` defined:
  - x = 11082240 leaves ovf = 0.
  - x = 11082241 sets ovf = 1, with out = 0.
  - ovf stays set through later in-range beats until reset.

Source files
------------

// File: rtl/modred_pkg.sv
// rtl/modred_pkg.sv - Shared constants and coefficient/product types for the Barrett reducer.
package modred_pkg;
    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_M = 5039;
    localparam int BARRETT_K = 24;
    localparam int KYBER_Q2  = 11082241;

    typedef logic [11:0] coeff_t;
    typedef logic [23:0] prod_t;
endpackage

// File: rtl/modred_csub.sv
// rtl/modred_csub.sv - Conditional subtract mapping r in [0, 2Q) onto [0, Q).
module modred_csub
    import modred_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [12:0] r,
    output coeff_t      y
);
    logic ge;

    assign ge = (r >= 13'(Q));
    assign y  = ge ? 12'(r - 13'(Q)) : r[11:0];
endmodule

// File: rtl/modred.sv
// rtl/modred.sv - Three-stage Barrett reducer x mod Q with tag sideband; MODRED_OVF_FLAG_EN adds sticky ovf.
module modred
    import modred_pkg::*;
#(
    parameter int Q     = KYBER_Q,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  prod_t            in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output coeff_t           out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef MODRED_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int M = (2 ** BARRETT_K) / Q;

    logic             adv;
    logic             v1, v2, v3;
    logic [12:0]      x1_lo, t1, r2;
    logic [TAG_W-1:0] tag1, tag2;
    coeff_t           red;

    (* use_dsp = "yes" *) logic [12:0] t_next;
    (* use_dsp = "yes" *) logic [12:0] tq_lo;

    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    assign t_next = 13'((37'(in_data) * 37'(M)) >> BARRETT_K);

    // r = x - t*Q is known to lie in [0, 2Q) < 2^13, so the subtraction is
    // exact when done modulo 2^13: only the low 13 bits of x and t*Q matter.
    assign tq_lo = t1 * 13'(Q);

    modred_csub #(.Q(Q)) u_csub (
        .r (r2),
        .y (red)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            x1_lo    <= '0;
            t1       <= '0;
            tag1     <= '0;
            r2       <= '0;
            tag2     <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                x1_lo <= in_data[12:0];
                t1    <= t_next;
                tag1  <= in_tag;
            end
            if (v1) begin
                r2   <= x1_lo - tq_lo;
                tag2 <= tag1;
            end
            if (v2) begin
                out_data <= red;
                out_tag  <= tag2;
            end
        end
    end

`ifdef MODRED_OVF_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (in_valid && in_ready && (in_data >= 24'(Q * Q))) begin
            ovf <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_modred.sv
// tb/tb_modred.sv - Self-checking bench for modred against an x % Q scoreboard.
module tb_modred;
    localparam int Q     = 3329;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [23:0]      in_data = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [11:0]      out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef MODRED_OVF_FLAG_EN
    logic             ovf;
`endif

    modred #(.Q(Q), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef MODRED_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int tag;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          held = 1'b0;
    logic [11:0] held_data;
    logic [TAG_W-1:0] held_tag;
    bit          ov_hist[0:65535];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes mid-cycle, score retirements, record acceptances.
    task automatic cycle(output bit acc);
        bit   ret;
        exp_t e;
        #2;
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        ov_hist[cyc] = out_valid;
        if (held) begin
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_tag", 32'(out_tag), 32'(held_tag));
        end
        if (exp_q.size() == 0) begin
            check("no_beat_in_flight_out_valid", 32'(out_valid), 32'd0);
        end else if (ret) begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_tag", 32'(out_tag), 32'(e.tag));
            if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
        if (acc) exp_q.push_back('{int'(in_data) % Q, int'(in_tag), cyc});
        held      = out_valid && !out_ready;
        held_data = out_data;
        held_tag  = out_tag;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [23:0] x, input logic [TAG_W-1:0] tag);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        in_tag   = tag;
        for (int i = 0; i < 50 && !acc; i++) cycle(acc);
        if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(a);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit          a;
        int          sent;
        int          start;
        logic [23:0] x;
        int          corners[5];
        bit          pat[5];

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MODRED_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Corner values, back to back, fixed latency
        corners = '{0, 3329, 3328, 11075584, 16777215};
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) send(24'(corners[i]), TAG_W'(8'hA0 + i));
        drain();
        lat_chk = 1'b0;

        // Random stream with random bubbles and backpressure
        sent = 0;
        x = 24'($urandom_range(0, Q * Q - 1));
        for (int i = 0; i < 40000 && sent < 10000; i++) begin
            in_valid  = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            in_data   = x;
            in_tag    = TAG_W'(sent);
            cycle(a);
            if (a) begin
                sent++;
                x = 24'($urandom_range(0, Q * Q - 1));
            end
        end
        check("random_sent", 32'(sent), 32'd10000);
        drain();

        // Backpressure: 6 beats, stall 4 cycles with beat 1 at the output
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 16777215)), TAG_W'(8'h10 + i));
        check("bp_beat1_at_output", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        in_data   = 24'($urandom_range(0, 16777215));
        in_tag    = TAG_W'(8'h13);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            cycle(a);
        end
        out_ready = 1'b1;
        send(in_data, in_tag);
        for (int i = 4; i < 6; i++) send(24'($urandom_range(0, 16777215)), TAG_W'(8'h10 + i));
        drain();

        // Bubbles: valid pattern 1,0,1,0,1 reappears 3 cycles later
        pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        sent  = 1;
        start = cyc;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i];
            in_data  = 24'($urandom_range(0, 16777215));
            in_tag   = TAG_W'(sent);
            if (pat[i]) sent++;
            cycle(a);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle(a);
        for (int i = 0; i < 5; i++) check("bubble_pattern", 32'(ov_hist[start + 3 + i]), 32'(pat[i]));
        drain();

        // Reset mid-stream with three beats in flight
        for (int i = 0; i < 3; i++) send(24'($urandom_range(0, 16777215)), TAG_W'(8'h30 + i));
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) cycle(a);
        send(24'd12345, TAG_W'(8'h55));
        drain();

`ifdef MODRED_OVF_FLAG_EN
        check("ovf_clear", 32'(ovf), 32'd0);
        send(24'd11082240, TAG_W'(8'h60));
        drain();
        check("ovf_below_q2", 32'(ovf), 32'd0);
        send(24'd11082241, TAG_W'(8'h61));
        check("ovf_set_at_q2", 32'(ovf), 32'd1);
        drain();
        for (int i = 0; i < 5; i++) send(24'($urandom_range(0, Q * Q - 1)), TAG_W'(8'h62 + i));
        drain();
        check("ovf_sticky", 32'(ovf), 32'd1);
        reset = 1'b0;
        #1;
        check("ovf_reset", 32'(ovf), 32'd0);
        exp_q.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
